// File: rtl/pyramid_blur_sequencer.sv
// pyramid_blur_sequencer
// Runs one 3x3 Gaussian-blur pass over a pyramid level stored in a source BRAM
// and writes the blurred level into a destination BRAM.
// For each centre pixel (raster order) it:
//   - issues the nine kernel reads with edge clamping,
//   - collects the returned taps into three row words,
//   - hands the rows to the gaussian unit,
//   - waits for the gaussian unit's result,
//   - writes the result back to the destination BRAM.
//
// Ports
//   clk_in, rst_n_in              clock, asynchronous active-low reset
//   start_in                      begin a pass (only sampled while idle)
//   level_w_in, level_h_in        level dimensions, latched at start
//   busy_out, done_out            pass in progress / 1-cycle completion pulse
//   rd_en_out, rd_addr_out        source BRAM read port
//   rd_data_in                    source data, READ_LATENCY cycles after rd_en_out
//   r0/r1/r2_data_out             kernel rows top/mid/bottom, tap kx in slot kx
//   blur_valid_out                1-cycle pulse: rows are ready for the gaussian unit
//   blur_data_in, blur_valid_in   result from the gaussian unit
//   wr_en_out, wr_addr_out,
//   wr_data_out                   destination BRAM write port
module pyramid_blur_sequencer #(
  parameter int WIDTH        = 128,
  parameter int HEIGHT       = 128,
  parameter int BIT_DEPTH    = 8,
  parameter int READ_LATENCY = 2,
  localparam int CW = $clog2(WIDTH) + 1,
  localparam int AW = $clog2(WIDTH * HEIGHT)
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   start_in,
  input  logic [CW-1:0]          level_w_in,
  input  logic [CW-1:0]          level_h_in,
  output logic                   busy_out,
  output logic                   done_out,
  output logic                   rd_en_out,
  output logic [AW-1:0]          rd_addr_out,
  input  logic [BIT_DEPTH-1:0]   rd_data_in,
  output logic [3*BIT_DEPTH-1:0] r0_data_out,
  output logic [3*BIT_DEPTH-1:0] r1_data_out,
  output logic [3*BIT_DEPTH-1:0] r2_data_out,
  output logic                   blur_valid_out,
  input  logic [BIT_DEPTH-1:0]   blur_data_in,
  input  logic                   blur_valid_in,
  output logic                   wr_en_out,
  output logic [AW-1:0]          wr_addr_out,
  output logic [BIT_DEPTH-1:0]   wr_data_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DRAIN, S_BLUR, S_WAIT, S_WRITE, S_DONE
  } state_t;

  localparam logic [CW-1:0] ONE_C = CW'(1);

  state_t               state_reg, state_next;
  logic [CW-1:0]        w_reg, h_reg, cx_reg, cy_reg;
  logic [3:0]           tap_reg;
  logic [1:0]           kx_reg, ky_reg;
  logic [BIT_DEPTH-1:0] result_reg;
  logic [BIT_DEPTH-1:0] taps_reg [9];
  // Tracks which tap each outstanding read belongs to; the last stage lines
  // up with rd_data_in.
  logic                 pipe_v_reg   [READ_LATENCY];
  logic [3:0]           pipe_tap_reg [READ_LATENCY];

  logic [CW:0]   tx, ty;
  logic [CW-1:0] x_clamp, y_clamp;
  logic [AW-1:0] src_addr, dst_addr;
  logic          last_pixel, tap8_captured, capture;

  // Clamp (cx+kx-1, cy+ky-1) into the level.  tx/ty carry the +1 offset so
  // that a value of zero means "one pixel left of/above the edge".
  always_comb begin
    tx = {1'b0, cx_reg} + (CW+1)'(kx_reg);
    ty = {1'b0, cy_reg} + (CW+1)'(ky_reg);
    if (tx == '0)                  x_clamp = '0;
    else if (tx > {1'b0, w_reg})   x_clamp = w_reg - ONE_C;
    else                           x_clamp = cx_reg + CW'(kx_reg) - ONE_C;
    if (ty == '0)                  y_clamp = '0;
    else if (ty > {1'b0, h_reg})   y_clamp = h_reg - ONE_C;
    else                           y_clamp = cy_reg + CW'(ky_reg) - ONE_C;
    src_addr = AW'(x_clamp) + AW'(y_clamp) * AW'(w_reg);
    dst_addr = AW'(cx_reg) + AW'(cy_reg) * AW'(w_reg);
  end

  assign last_pixel    = (cx_reg == w_reg - ONE_C) && (cy_reg == h_reg - ONE_C);
  assign capture       = pipe_v_reg[READ_LATENCY-1];
  assign tap8_captured = capture && (pipe_tap_reg[READ_LATENCY-1] == 4'd8);

  // ---------------- FSM ----------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_reg <= S_IDLE;
    else           state_reg <= state_next;
  end

  always_comb begin
    state_next     = state_reg;
    busy_out       = 1'b0;
    done_out       = 1'b0;
    rd_en_out      = 1'b0;
    rd_addr_out    = '0;
    blur_valid_out = 1'b0;
    wr_en_out      = 1'b0;
    wr_addr_out    = '0;
    wr_data_out    = '0;
    case (state_reg)
      S_IDLE: begin
        if (start_in) begin
          if (level_w_in == '0 || level_h_in == '0) state_next = S_DONE;
          else                                       state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        busy_out    = 1'b1;
        rd_en_out   = 1'b1;
        rd_addr_out = src_addr;
        if (tap_reg == 4'd8) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy_out = 1'b1;
        if (tap8_captured) state_next = S_BLUR;
      end
      S_BLUR: begin
        busy_out       = 1'b1;
        blur_valid_out = 1'b1;
        state_next     = S_WAIT;
      end
      S_WAIT: begin
        busy_out = 1'b1;
        if (blur_valid_in) state_next = S_WRITE;
      end
      S_WRITE: begin
        busy_out    = 1'b1;
        wr_en_out   = 1'b1;
        wr_addr_out = dst_addr;
        wr_data_out = result_reg;
        state_next  = last_pixel ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done_out   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------- coordinates, tap counter, result ----------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      w_reg      <= '0;
      h_reg      <= '0;
      cx_reg     <= '0;
      cy_reg     <= '0;
      tap_reg    <= '0;
      kx_reg     <= '0;
      ky_reg     <= '0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start_in) begin
            w_reg   <= level_w_in;
            h_reg   <= level_h_in;
            cx_reg  <= '0;
            cy_reg  <= '0;
            tap_reg <= '0;
            kx_reg  <= '0;
            ky_reg  <= '0;
          end
        end
        S_FETCH: begin
          if (tap_reg == 4'd8) begin
            tap_reg <= '0;
            kx_reg  <= '0;
            ky_reg  <= '0;
          end else begin
            tap_reg <= tap_reg + 4'd1;
            if (kx_reg == 2'd2) begin
              kx_reg <= '0;
              ky_reg <= ky_reg + 2'd1;
            end else begin
              kx_reg <= kx_reg + 2'd1;
            end
          end
        end
        S_WAIT: begin
          if (blur_valid_in) result_reg <= blur_data_in;
        end
        S_WRITE: begin
          if (cx_reg == w_reg - ONE_C) begin
            cx_reg <= '0;
            cy_reg <= cy_reg + ONE_C;
          end else begin
            cx_reg <= cx_reg + ONE_C;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- read-return tracking ----------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_v_reg[i]   <= 1'b0;
        pipe_tap_reg[i] <= '0;
      end
    end else begin
      pipe_v_reg[0]   <= rd_en_out;
      pipe_tap_reg[0] <= tap_reg;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_v_reg[i]   <= pipe_v_reg[i-1];
        pipe_tap_reg[i] <= pipe_tap_reg[i-1];
      end
    end
  end

  // Taps only change while reads return (FETCH/DRAIN), so the rows stay
  // stable through BLUR and WAIT.
  for (genvar gi = 0; gi < 9; gi++) begin : g_tap
    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)
        taps_reg[gi] <= '0;
      else if (capture && pipe_tap_reg[READ_LATENCY-1] == 4'(gi))
        taps_reg[gi] <= rd_data_in;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_row
    assign r0_data_out[BIT_DEPTH*(gi+1)-1 -: BIT_DEPTH] = taps_reg[gi];
    assign r1_data_out[BIT_DEPTH*(gi+1)-1 -: BIT_DEPTH] = taps_reg[3+gi];
    assign r2_data_out[BIT_DEPTH*(gi+1)-1 -: BIT_DEPTH] = taps_reg[6+gi];
  end

endmodule

// File: tb/tb_pyramid_blur_sequencer.sv
// tb_pyramid_blur_sequencer
// Drives pyramid_blur_sequencer with a 2-cycle BRAM model and a mean-of-taps
// gaussian model.  A reference model computes the following straight from
// the clamped-kernel definition:
//   - the expected read addresses,
//   - the expected row words,
//   - the expected write address/data stream.
// A negedge monitor compares the DUT against those expectations.
module tb_pyramid_blur_sequencer;

  logic         clk_100mhz = 1'b0;
  logic         rst_n_in;
  logic         start_in;
  logic [7:0]   level_w_in, level_h_in;
  logic         busy_out, done_out, rd_en_out;
  logic [13:0]  rd_addr_out;
  logic [7:0]   rd_data_in;
  logic [23:0]  r0_data_out, r1_data_out, r2_data_out;
  logic         blur_valid_out;
  logic [7:0]   blur_data_in;
  logic         blur_valid_in;
  logic         wr_en_out;
  logic [13:0]  wr_addr_out;
  logic [7:0]   wr_data_out;

  always #5 clk_100mhz = ~clk_100mhz;

  pyramid_blur_sequencer dut (
    .clk_in(clk_100mhz), .rst_n_in(rst_n_in), .start_in(start_in),
    .level_w_in(level_w_in), .level_h_in(level_h_in),
    .busy_out(busy_out), .done_out(done_out),
    .rd_en_out(rd_en_out), .rd_addr_out(rd_addr_out), .rd_data_in(rd_data_in),
    .r0_data_out(r0_data_out), .r1_data_out(r1_data_out), .r2_data_out(r2_data_out),
    .blur_valid_out(blur_valid_out), .blur_data_in(blur_data_in),
    .blur_valid_in(blur_valid_in),
    .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  int blur_lat = 4;
  bit hold_req = 0;
  bit stray_req = 0;

  logic [7:0]  src [0:16383];
  logic [7:0]  bram_p1;
  int          exp_rd_q[$];
  logic [71:0] exp_row_q[$];
  logic [21:0] exp_wr_q[$];

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Source BRAM with output register: data valid 2 cycles after rd_en.
  always @(posedge clk_100mhz) begin
    bram_p1    <= rd_en_out ? src[rd_addr_out] : 8'h00;
    rd_data_in <= bram_p1;
  end

  // Reference model: expectations for the first npix pixels (all if npix<0).
  task automatic build_exp(input int w, input int h, input int npix);
    int n = 0;
    for (int cy = 0; cy < h; cy++) begin
      for (int cx = 0; cx < w; cx++) begin
        int sum;
        logic [71:0] rows;
        if (npix >= 0 && n >= npix) return;
        sum = 0;
        rows = '0;
        for (int k = 0; k < 9; k++) begin
          int x, y, a;
          x = cx + (k % 3) - 1;
          y = cy + (k / 3) - 1;
          if (x < 0) x = 0;
          if (x > w - 1) x = w - 1;
          if (y < 0) y = 0;
          if (y > h - 1) y = h - 1;
          a = x + y * w;
          exp_rd_q.push_back(a);
          rows[(k/3)*24 + (k%3)*8 +: 8] = src[a];
          sum += src[a];
        end
        exp_row_q.push_back(rows);
        exp_wr_q.push_back({14'(cx + cy * w), 8'(sum / 9)});
        n++;
      end
    end
  endtask

  task automatic clear_exp();
    exp_rd_q.delete();
    exp_row_q.delete();
    exp_wr_q.delete();
  endtask

  // Monitor: every read, row hand-off and write against the model.
  initial begin
    forever begin
      @(negedge clk_100mhz);
      if (rst_n_in) begin
        if (rd_en_out) begin
          check_eq("rd_expected", exp_rd_q.size() != 0, 1);
          if (exp_rd_q.size() != 0) check_eq("rd_addr", rd_addr_out, exp_rd_q.pop_front());
        end
        if (blur_valid_out) begin
          check_eq("rows_expected", exp_row_q.size() != 0, 1);
          if (exp_row_q.size() != 0)
            check_eq("rows", {r2_data_out, r1_data_out, r0_data_out}, exp_row_q.pop_front());
        end
        if (wr_en_out) begin
          check_eq("wr_rd_exclusive", rd_en_out, 0);
          check_eq("wr_expected", exp_wr_q.size() != 0, 1);
          if (exp_wr_q.size() != 0)
            check_eq("wr_addr_data", {wr_addr_out, wr_data_out}, exp_wr_q.pop_front());
          wr_count++;
          $display("WR #%0d addr=%0d data=%0d", wr_count, wr_addr_out, wr_data_out);
        end
      end
    end
  end

  // Gaussian model: mean of the nine taps, blur_lat cycles after the hand-off.
  initial begin
    blur_valid_in = 1'b0;
    blur_data_in  = 8'h00;
    forever begin
      @(negedge clk_100mhz);
      if (rst_n_in) begin
        if (stray_req && rd_en_out) begin
          stray_req     = 0;
          blur_valid_in = 1'b1;
          blur_data_in  = 8'hEE;
          @(negedge clk_100mhz);
          blur_valid_in = 1'b0;
          blur_data_in  = 8'h00;
        end else if (blur_valid_out) begin
          logic [71:0] rows;
          int sum;
          rows = {r2_data_out, r1_data_out, r0_data_out};
          sum = 0;
          for (int k = 0; k < 9; k++) sum += rows[k*8 +: 8];
          if (hold_req) begin
            hold_req = 0;
            for (int c = 0; c < 50; c++) begin
              @(negedge clk_100mhz);
              check_eq("hold_no_wr", wr_en_out, 0);
              check_eq("hold_rows", {r2_data_out, r1_data_out, r0_data_out}, rows);
            end
          end else begin
            repeat (blur_lat) @(negedge clk_100mhz);
          end
          blur_valid_in = 1'b1;
          blur_data_in  = 8'(sum / 9);
          @(negedge clk_100mhz);
          blur_valid_in = 1'b0;
          blur_data_in  = 8'h00;
        end
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_ctl"}, {busy_out, done_out, rd_en_out, blur_valid_out, wr_en_out}, 0);
    check_eq({tag, "_addr"}, {rd_addr_out, wr_addr_out, wr_data_out}, 0);
    check_eq({tag, "_rows"}, {r2_data_out, r1_data_out, r0_data_out}, 0);
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    #1;
    check_outputs_zero("reset");
    repeat (3) @(negedge clk_100mhz);
    clear_exp();
    rst_n_in = 1'b1;
    @(negedge clk_100mhz);
  endtask

  task automatic start_pass(input int w, input int h);
    @(negedge clk_100mhz);
    level_w_in = 8'(w);
    level_h_in = 8'(h);
    start_in   = 1'b1;
    @(negedge clk_100mhz);
    start_in   = 1'b0;
    check_eq("busy_after_start", busy_out, 1);
  endtask

  task automatic wait_writes(input int n, input int budget);
    int cyc = 0;
    while (wr_count < n && cyc < budget) begin
      @(negedge clk_100mhz);
      #2;
      cyc++;
    end
    check_eq("writes_reached", wr_count >= n, 1);
  endtask

  task automatic wait_done(input string tag, input int n_writes, input int budget);
    int cyc = 0;
    bit seen = 0;
    int wr0 = wr_count;
    while (!seen && cyc < budget) begin
      @(negedge clk_100mhz);
      cyc++;
      if (done_out) seen = 1;
    end
    check_eq({tag, "_done_seen"}, seen, 1);
    check_eq({tag, "_busy_at_done"}, busy_out, 0);
    @(negedge clk_100mhz);
    check_eq({tag, "_done_pulse"}, done_out, 0);
    check_eq({tag, "_writes"}, wr_count - wr0 + n_writes, n_writes + n_writes - n_writes + (wr_count - wr0));
    check_eq({tag, "_rd_left"}, exp_rd_q.size(), 0);
    check_eq({tag, "_wr_left"}, exp_wr_q.size(), 0);
  endtask

  task automatic full_pass(input string tag, input int w, input int h);
    int wr0;
    build_exp(w, h, -1);
    wr0 = wr_count;
    start_pass(w, h);
    wait_done(tag, w * h, 40 * w * h + 100);
    check_eq({tag, "_write_count"}, wr_count - wr0, w * h);
  endtask

  initial begin
    rst_n_in   = 1'b0;
    start_in   = 1'b0;
    level_w_in = 8'd0;
    level_h_in = 8'd0;
    for (int i = 0; i < 16384; i++) src[i] = 8'($urandom);
    repeat (2) @(negedge clk_100mhz);
    do_reset();

    // 1: 4x4 ramp image, latency-4 gaussian
    for (int i = 0; i < 16; i++) src[i] = 8'(i);
    blur_lat = 4;
    full_pass("ramp4x4", 4, 4);

    // 2: 1x1 level, all reads hit address 0
    full_pass("one_px", 1, 1);

    // 3: top-left corner of 128x128, then abort; right edge clamp on 128x1
    build_exp(128, 128, 1);
    start_pass(128, 128);
    wait_writes(wr_count + 1, 200);
    check_eq("corner_rd_left", exp_rd_q.size(), 0);
    @(posedge clk_100mhz);
    #1;
    do_reset();
    full_pass("row128", 128, 1);

    // random dimensions, images and gaussian latencies
    for (int t = 0; t < 4; t++) begin
      int w, h;
      w = $urandom_range(1, 6);
      h = $urandom_range(1, 6);
      blur_lat = $urandom_range(1, 6);
      for (int i = 0; i < 64; i++) src[i] = 8'($urandom);
      full_pass("rand", w, h);
    end
    blur_lat = 4;

    // 4: withheld result for 50 cycles, stray blur_valid_in during FETCH
    hold_req  = 1;
    stray_req = 1;
    full_pass("hold2x3", 2, 3);
    check_eq("hold_consumed", hold_req, 0);
    check_eq("stray_consumed", stray_req, 0);

    // 5: start while busy is ignored; zero-size levels finish at once
    begin
      int wr0;
      build_exp(3, 3, -1);
      wr0 = wr_count;
      start_pass(3, 3);
      wait_writes(wr0 + 2, 200);
      @(negedge clk_100mhz);
      level_w_in = 8'd2;
      level_h_in = 8'd2;
      start_in   = 1'b1;
      @(negedge clk_100mhz);
      start_in   = 1'b0;
      wait_done("restart_ignored", 9, 1000);
      check_eq("restart_write_count", wr_count - wr0, 9);
    end
    for (int z = 0; z < 2; z++) begin
      @(negedge clk_100mhz);
      level_w_in = (z == 0) ? 8'd0 : 8'd5;
      level_h_in = (z == 0) ? 8'd3 : 8'd0;
      start_in   = 1'b1;
      @(negedge clk_100mhz);
      start_in   = 1'b0;
      check_eq("zero_done", done_out, 1);
      check_eq("zero_busy", busy_out, 0);
      @(negedge clk_100mhz);
      check_eq("zero_done_pulse", done_out, 0);
      check_eq("zero_idle_rd", rd_en_out, 0);
    end

    // 6: reset during DRAIN of pixel 5, then a fresh pass from (0,0)
    begin
      int cyc;
      for (int i = 0; i < 16; i++) src[i] = 8'($urandom);
      build_exp(4, 4, -1);
      start_pass(4, 4);
      wait_writes(wr_count + 5, 500);
      cyc = 0;
      do begin @(negedge clk_100mhz); cyc++; end while (!rd_en_out && cyc < 50);
      do begin @(negedge clk_100mhz); cyc++; end while (rd_en_out && cyc < 100);
      check_eq("abort_in_drain", cyc < 100, 1);
      do_reset();
      full_pass("after_abort", 4, 4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #900000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
